// File: rtl/mwc_pkg.sv
// Shared state codes, expected-entry layout and width helpers for the data-memory write checker.
package mwc_pkg;

  localparam int unsigned XLEN_DEF = 32;

  typedef logic [1:0] mwc_state_t;

  localparam mwc_state_t ST_RUN     = 2'd0;
  localparam mwc_state_t ST_PASS    = 2'd1;
  localparam mwc_state_t ST_FAIL    = 2'd2;
  localparam mwc_state_t ST_TIMEOUT = 2'd3;

  typedef struct packed {
    logic [XLEN_DEF-1:0] addr;
    logic [XLEN_DEF-1:0] data;
  } mwc_entry_t;

  // Width of a counter that must hold 0..n inclusive.
  function automatic int unsigned mwc_cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int unsigned mwc_ptr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mwc_if.sv
// Data-memory write port as seen by the checker: store strobe, address and data.
interface mwc_if #(
  parameter int unsigned XLEN = 32
);
  logic            MemWrite;
  logic [XLEN-1:0] DataAdr;
  logic [XLEN-1:0] WriteData;

  modport master (output MemWrite, output DataAdr, output WriteData);
  modport slave  (input  MemWrite, input  DataAdr, input  WriteData);
endinterface

// File: rtl/mwc_expect_rom.sv
// Expected-write table: entry i is EXP_TABLE[i*2*XLEN +: 2*XLEN] = {addr, data}.
// Provides an indexed read for in-order checking and the whole table for unordered checking.
module mwc_expect_rom #(
  parameter int unsigned                   XLEN       = 32,
  parameter int unsigned                   NUM_CHECKS = 4,
  parameter int unsigned                   CNT_W      = 3,
  parameter logic [NUM_CHECKS*2*XLEN-1:0]  EXP_TABLE  = '0
) (
  input  logic [CNT_W-1:0]                     idx,
  output logic [2*XLEN-1:0]                    rd_entry,
  output logic [NUM_CHECKS-1:0][2*XLEN-1:0]    entries
);

  assign entries = EXP_TABLE;

  // Index past the last entry reads as zero rather than out of range.
  always_comb begin
    rd_entry = '0;
    for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
      if (idx == CNT_W'(i)) rd_entry = entries[i];
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Store monitor: matches data-memory writes against a table, reports PASS/FAIL/TIMEOUT.
// MWC_STRICT_EN: when defined, a store matching no outstanding entry fails the run.
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int unsigned                   XLEN           = 32,
  parameter int unsigned                   NUM_CHECKS     = 4,
  parameter int unsigned                   TIMEOUT_CYCLES = 200,
  parameter bit                            ORDERED        = 1'b1,
  parameter logic [NUM_CHECKS*2*XLEN-1:0]  EXP_TABLE      = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  mwc_if.slave                               bus,
  output logic                               done,
  output logic                               pass,
  output logic                               fail,
  output logic                               timeout,
  output logic [mwc_cnt_w(NUM_CHECKS)-1:0]   match_count,
  output logic [XLEN-1:0]                    fail_addr,
  output logic [XLEN-1:0]                    fail_data
);

  localparam int unsigned CNT_W  = mwc_cnt_w(NUM_CHECKS);
  localparam int unsigned WDOG_W = mwc_ptr_w(TIMEOUT_CYCLES);

`ifdef MWC_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  mwc_state_t                           state;
  logic [WDOG_W-1:0]                    wdog;
  logic [CNT_W-1:0]                     count;
  logic [NUM_CHECKS-1:0]                hit_mask;

  logic [2*XLEN-1:0]                    rd_entry;
  logic [NUM_CHECKS-1:0][2*XLEN-1:0]    entries;

  logic                                 store;
  logic                                 full_match;
  logic                                 data_miss;
  logic                                 addr_seen;
  logic [NUM_CHECKS-1:0]                hit_now;
  logic                                 match_now;
  logic                                 fail_now;

  mwc_expect_rom #(
    .XLEN       (XLEN),
    .NUM_CHECKS (NUM_CHECKS),
    .CNT_W      (CNT_W),
    .EXP_TABLE  (EXP_TABLE)
  ) u_rom (
    .idx      (count),
    .rd_entry (rd_entry),
    .entries  (entries)
  );

  always_comb begin
    store      = (bus.MemWrite === 1'b1);
    full_match = 1'b0;
    data_miss  = 1'b0;
    addr_seen  = 1'b0;
    hit_now    = '0;
    if (ORDERED) begin
      if (rd_entry[2*XLEN-1:XLEN] == bus.DataAdr) begin
        full_match = (rd_entry[XLEN-1:0] == bus.WriteData);
        data_miss  = !full_match;
      end
    end else begin
      // Lowest-index outstanding full match claims the store.
      for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
        if (!hit_mask[i] && !full_match && (entries[i] == {bus.DataAdr, bus.WriteData})) begin
          full_match = 1'b1;
          hit_now[i] = 1'b1;
        end
      end
      for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
        if (!hit_mask[i] && (entries[i][2*XLEN-1:XLEN] == bus.DataAdr)) addr_seen = 1'b1;
      end
      data_miss = addr_seen && !full_match;
    end
  end

  assign match_now = store && full_match;
  assign fail_now  = store && (data_miss || (STRICT && !full_match));

  // Final match takes priority over a watchdog expiring on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      wdog      <= '0;
      count     <= '0;
      hit_mask  <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (state == ST_RUN) begin
      if (match_now) begin
        count    <= count + CNT_W'(1);
        hit_mask <= hit_mask | hit_now;
      end
      if (match_now && (count == CNT_W'(NUM_CHECKS - 1))) begin
        state <= ST_PASS;
      end else if (fail_now) begin
        state     <= ST_FAIL;
        fail_addr <= bus.DataAdr;
        fail_data <= bus.WriteData;
      end else if (wdog == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
        state <= ST_TIMEOUT;
      end else begin
        wdog <= wdog + WDOG_W'(1);
      end
    end
  end

  assign done        = (state != ST_RUN);
  assign pass        = (state == ST_PASS);
  assign fail        = (state == ST_FAIL);
  assign timeout     = (state == ST_TIMEOUT);
  assign match_count = count;

endmodule

// File: tb/tb_mem_write_checker.sv
// Scoreboard bench: three checkers (ordered, unordered, single-entry short watchdog) on one store bus.
module tb_mem_write_checker;
  import mwc_pkg::*;

`ifdef MWC_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  localparam logic [63:0]  E0     = {32'h0000_0060, 32'd7};
  localparam logic [63:0]  E1     = {32'h0000_0064, 32'd25};
  localparam logic [63:0]  E2     = {32'h0000_0068, 32'hDEAD_BEEF};
  localparam logic [63:0]  E3     = {32'h0000_006C, 32'h1234_5678};
  localparam logic [255:0] TABLE4 = {E3, E2, E1, E0};
  localparam logic [63:0]  TABLE1 = E1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mwc_if #(.XLEN(32)) bus ();

  logic [2:0]  done_v, pass_v, fail_v, tmo_v;
  logic [2:0]  cnt_a, cnt_b;
  logic [0:0]  cnt_c;
  logic [31:0] fa_a, fd_a, fa_b, fd_b, fa_c, fd_c;

  mem_write_checker #(
    .XLEN(32), .NUM_CHECKS(4), .TIMEOUT_CYCLES(200), .ORDERED(1'b1), .EXP_TABLE(TABLE4)
  ) u_ord (
    .clk(clk), .reset(reset), .bus(bus),
    .done(done_v[0]), .pass(pass_v[0]), .fail(fail_v[0]), .timeout(tmo_v[0]),
    .match_count(cnt_a), .fail_addr(fa_a), .fail_data(fd_a)
  );

  mem_write_checker #(
    .XLEN(32), .NUM_CHECKS(4), .TIMEOUT_CYCLES(200), .ORDERED(1'b0), .EXP_TABLE(TABLE4)
  ) u_unord (
    .clk(clk), .reset(reset), .bus(bus),
    .done(done_v[1]), .pass(pass_v[1]), .fail(fail_v[1]), .timeout(tmo_v[1]),
    .match_count(cnt_b), .fail_addr(fa_b), .fail_data(fd_b)
  );

  mem_write_checker #(
    .XLEN(32), .NUM_CHECKS(1), .TIMEOUT_CYCLES(12), .ORDERED(1'b1), .EXP_TABLE(TABLE1)
  ) u_one (
    .clk(clk), .reset(reset), .bus(bus),
    .done(done_v[2]), .pass(pass_v[2]), .fail(fail_v[2]), .timeout(tmo_v[2]),
    .match_count(cnt_c), .fail_addr(fa_c), .fail_data(fd_c)
  );

  // Reference model: outcome of each run as a list of outstanding entries.
  mwc_entry_t  tbl [3][4];
  int          nchk [3] = '{4, 4, 1};
  int          tmo_n [3] = '{200, 200, 12};
  bit          ordk [3] = '{1'b1, 1'b0, 1'b1};
  int          m_st [3];   // 0 running, 1 pass, 2 fail, 3 timeout
  int          m_cnt [3];
  int          m_cyc [3];
  bit          m_hit [3][4];
  logic [31:0] m_fa [3];
  logic [31:0] m_fd [3];

  logic [75:0] q0 [$];
  logic [75:0] q1 [$];
  logic [75:0] q2 [$];

  int checks   = 0;
  int failures = 0;
  int cyc_no   = 0;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; m_cnt[k] = 0; m_cyc[k] = 0; m_fa[k] = '0; m_fd[k] = '0;
      for (int i = 0; i < 4; i++) m_hit[k][i] = 1'b0;
    end
  endtask

  task automatic model_step(int k, bit we, logic [31:0] a, logic [31:0] d);
    bit hit = 1'b0;
    bit bad = 1'b0;
    int j = -1;
    if (m_st[k] != 0) return;
    if (we) begin
      if (ordk[k]) begin
        if (tbl[k][m_cnt[k]].addr == a) begin
          if (tbl[k][m_cnt[k]].data == d) hit = 1'b1; else bad = 1'b1;
        end else bad = STRICT;
      end else begin
        for (int i = 0; i < nchk[k]; i++)
          if (j < 0 && !m_hit[k][i] && tbl[k][i].addr == a) j = i;
        if (j < 0) bad = STRICT;
        else if (tbl[k][j].data == d) begin hit = 1'b1; m_hit[k][j] = 1'b1; end
        else bad = 1'b1;
      end
    end
    if (hit) begin
      m_cnt[k]++;
      if (m_cnt[k] == nchk[k]) begin m_st[k] = 1; return; end
    end
    if (bad) begin m_st[k] = 2; m_fa[k] = a; m_fd[k] = d; return; end
    if (m_cyc[k] == tmo_n[k] - 1) m_st[k] = 3;
    else m_cyc[k]++;
  endtask

  function automatic logic [75:0] expv(int k);
    return {m_st[k] != 0, m_st[k] == 1, m_st[k] == 2, m_st[k] == 3, 8'(m_cnt[k]), m_fa[k], m_fd[k]};
  endfunction

  function automatic logic [75:0] obs(int k);
    case (k)
      0:       return {done_v[0], pass_v[0], fail_v[0], tmo_v[0], 8'(cnt_a), fa_a, fd_a};
      1:       return {done_v[1], pass_v[1], fail_v[1], tmo_v[1], 8'(cnt_b), fa_b, fd_b};
      default: return {done_v[2], pass_v[2], fail_v[2], tmo_v[2], 8'(cnt_c), fa_c, fd_c};
    endcase
  endfunction

  task automatic check(string name, int k, logic [75:0] act, logic [75:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s dut%0d cycle %0d: got done,pass,fail,tmo=%b cnt=%0d addr=%h data=%h; want %b cnt=%0d addr=%h data=%h",
               name, k, cyc_no, act[75:72], act[71:64], act[63:32], act[31:0],
               req[75:72], req[71:64], req[63:32], req[31:0]);
    end
  endtask

  // Monitor: every edge that had stimulus issued for it is compared once the outputs settle.
  always @(posedge clk) begin
    #1;
    cyc_no++;
    if (q0.size() > 0) check("outputs", 0, obs(0), q0.pop_front());
    if (q1.size() > 0) check("outputs", 1, obs(1), q1.pop_front());
    if (q2.size() > 0) check("outputs", 2, obs(2), q2.pop_front());
  end

  // One clock of stimulus; called at a falling edge, returns at the next one.
  task automatic drive(bit we, logic [31:0] a, logic [31:0] d);
    bus.MemWrite  = we;
    bus.DataAdr   = a;
    bus.WriteData = d;
    for (int k = 0; k < 3; k++) model_step(k, we, a, d);
    q0.push_back(expv(0));
    q1.push_back(expv(1));
    q2.push_back(expv(2));
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom, $urandom);
  endtask

  task automatic store_entry(logic [63:0] e);
    drive(1'b1, e[63:32], e[31:0]);
  endtask

  task automatic pulse_reset();
    bus.MemWrite = 1'b0;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) check("reset_immediate", k, obs(k), 76'd0);
    model_reset();
    q0.push_back(expv(0));
    q1.push_back(expv(1));
    q2.push_back(expv(2));
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got still running, want finished");
    $fatal(1);
  end

  initial begin
    logic [63:0] tbl4 [4];
    int unsigned pick;
    int unsigned e;
    tbl4[0] = E0; tbl4[1] = E1; tbl4[2] = E2; tbl4[3] = E3;
    for (int i = 0; i < 4; i++) begin
      tbl[0][i] = tbl4[i];
      tbl[1][i] = tbl4[i];
      tbl[2][i] = (i == 0) ? E1 : 64'd0;
    end
    bus.MemWrite = 1'b0; bus.DataAdr = '0; bus.WriteData = '0;
    @(negedge clk);

    // Single store at cycle 10
    pulse_reset();
    idle(10);
    store_entry(E1);
    idle(3);

    // Out-of-order first store, then the table in order and a repeat of a matched address
    pulse_reset();
    store_entry(E1); store_entry(E0); store_entry(E1); store_entry(E2); store_entry(E3);
    idle(3);

    // Data mismatch, later stores ignored
    pulse_reset();
    drive(1'b1, 32'h64, 32'd26);
    store_entry(E0); store_entry(E1);
    idle(2);

    // No stores: watchdog expiry for all three
    pulse_reset();
    idle(205);

    // Reverse order
    pulse_reset();
    store_entry(E3); store_entry(E2); store_entry(E1); store_entry(E0);
    idle(3);

    // Reset after one match, then a full rerun
    pulse_reset();
    store_entry(E0);
    idle(2);
    pulse_reset();
    store_entry(E0); store_entry(E1); store_entry(E2); store_entry(E3);
    idle(2);

    // Final match on the watchdog-expiry edge
    pulse_reset();
    idle(11);
    store_entry(E1);
    idle(2);
    pulse_reset();
    idle(196);
    store_entry(E0); store_entry(E1); store_entry(E2); store_entry(E3);
    idle(2);

    // One edge too late for the single-entry checker
    pulse_reset();
    idle(12);
    store_entry(E1);
    idle(2);

    // Randomized runs
    for (int r = 0; r < 20; r++) begin
      pulse_reset();
      for (int c = 0; c < 70; c++) begin
        pick = $urandom_range(0, 19);
        e    = $urandom_range(0, 3);
        if (pick < 10 && m_cnt[0] < 4 && $urandom_range(0, 1) == 1) e = m_cnt[0];
        if (pick < 6)       idle(1);
        else if (pick < 18) store_entry(tbl4[e]);
        else if (pick == 18) drive(1'b1, tbl4[e][63:32], tbl4[e][31:0] ^ (32'd1 << $urandom_range(0, 31)));
        else                 drive(1'b1, 32'h100 + ($urandom_range(0, 15) << 2), $urandom);
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
